spike_rate_decoder: RTL and testbench

Receiving end of the oscillator network's spike output. Samples a single-bit spike line, detects rising edges, counts spikes over a fixed window, and measures the inter-spike interval (ISI). Results go to the top level through a valid/ready handshake for display or readout. Sits downstream of the synapse OR-combined spike line in the top level.

---
 rtl/spike_rate_decoder.sv | 155 +++++++++++++++
 tb/tb_spike_rate_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: samples a single-bit spike line, detects rising edges, counts spikes per
// fixed window and measures the inter-spike interval. Window results leave through a
// valid/ready handshake; ISI results are a one-cycle pulse.
// Optional feature macro: SPIKE_DEC_SYNC_EN adds a two-flop input synchronizer for
// asynchronous spike sources (2 extra cycles of edge latency).
module spike_rate_decoder #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned ISI_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             overrun
);

  localparam int unsigned    WinW    = $clog2(WINDOW_CYCLES);
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [ISI_W-1:0] IsiMax = '1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] rate_out_q, rate_out_d;
  logic             rate_valid_q, rate_valid_d;
  logic [ISI_W-1:0] isi_out_q, isi_out_d;
  logic             isi_valid_q, isi_valid_d;
  logic             overrun_q, overrun_d;
  logic             prev_q;
  logic             spike_s;
  logic             rise;

`ifdef SPIKE_DEC_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for spike sources not synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= spike_in;
      sync2_q <= sync1_q;
    end
  end

  assign spike_s = sync2_q;
`else
  assign spike_s = spike_in;
`endif

  // A level held high for many cycles produces a single rise.
  assign rise = spike_s & ~prev_q;

  // Saturating spike count including the current cycle's rise.
  assign cnt_inc = (rise && (cnt_q != CntMax)) ? cnt_q + 1'b1 : cnt_q;

  // Next-state for FSM, window/ISI counters and result registers.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    isi_cnt_d    = isi_cnt_q;
    seen_d       = seen_q;
    rate_out_d   = rate_out_q;
    rate_valid_d = rate_valid_q & ~rate_ready;
    isi_out_d    = isi_out_q;
    isi_valid_d  = 1'b0;
    overrun_d    = overrun_q;

    if (!ena) begin
      // Partial window is discarded; a pending result stays until accepted.
      state_d   = StIdle;
      win_d     = '0;
      cnt_d     = '0;
      isi_cnt_d = '0;
      seen_d    = 1'b0;
      overrun_d = 1'b0;
    end else if (state_q == StIdle) begin
      state_d = StRun;
    end else begin
      if (win_q == WinLast) begin
        win_d        = '0;
        cnt_d        = '0;
        rate_out_d   = cnt_inc;
        rate_valid_d = 1'b1;
        if (rate_valid_q && !rate_ready) begin
          overrun_d = 1'b1;
        end
      end else begin
        win_d = win_q + 1'b1;
        cnt_d = cnt_inc;
      end

      if (rise) begin
        seen_d    = 1'b1;
        isi_cnt_d = ISI_W'(1);
        // The first rise after entering RUN only arms the interval measurement.
        if (seen_q) begin
          isi_out_d   = isi_cnt_q;
          isi_valid_d = 1'b1;
        end
      end else if (isi_cnt_q != IsiMax) begin
        isi_cnt_d = isi_cnt_q + 1'b1;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      win_q        <= '0;
      cnt_q        <= '0;
      isi_cnt_q    <= '0;
      seen_q       <= 1'b0;
      rate_out_q   <= '0;
      rate_valid_q <= 1'b0;
      isi_out_q    <= '0;
      isi_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      prev_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      isi_cnt_q    <= isi_cnt_d;
      seen_q       <= seen_d;
      rate_out_q   <= rate_out_d;
      rate_valid_q <= rate_valid_d;
      isi_out_q    <= isi_out_d;
      isi_valid_q  <= isi_valid_d;
      overrun_q    <= overrun_d;
      prev_q       <= spike_s;
    end
  end

  assign rate_out   = rate_out_q;
  assign rate_valid = rate_valid_q;
  assign isi_out    = isi_out_q;
  assign isi_valid  = isi_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: scoreboard queues of expected window counts and ISI values,
// popped by a monitor as the DUT hands results out. Small window and narrow result widths let
// the saturation cases run quickly.
module tb_spike_rate_decoder;

  localparam int unsigned WindowCycles = 16;
  localparam int unsigned CntW         = 3;
  localparam int unsigned IsiW         = 4;
`ifdef SPIKE_DEC_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic            clk;
  logic            rst_n;
  logic            ena;
  logic            spike_in;
  logic [CntW-1:0] rate_out;
  logic            rate_valid;
  logic            rate_ready;
  logic [IsiW-1:0] isi_out;
  logic            isi_valid;
  logic            overrun;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rate_q[$];
  int unsigned isi_q[$];

  spike_rate_decoder #(
    .WINDOW_CYCLES(WindowCycles),
    .CNT_W        (CntW),
    .ISI_W        (IsiW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .rate_out  (rate_out),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .isi_out   (isi_out),
    .isi_valid (isi_valid),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ena        = 1'b0;
    spike_in   = 1'b0;
    rate_ready = 1'b1;
    repeat (n) tick();
  endtask

  // Drive ena=1 and one pattern bit per cycle; the DUT enters RUN on the first edge.
  task automatic run_pat(input int n, input logic [127:0] pat, input logic rdy);
    for (int c = 0; c < n; c++) begin
      ena        = 1'b1;
      rate_ready = rdy;
      spike_in   = pat[c];
      tick();
    end
  endtask

  function automatic logic [127:0] periodic(input int n, input int per);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < n; i++) begin
      if (i % per == 0) p[i] = 1'b1;
    end
    return p;
  endfunction

  task automatic check_drained(input string tag);
    check_eq({tag, "_rate_q_empty"}, rate_q.size(), 0);
    check_eq({tag, "_isi_q_empty"}, isi_q.size(), 0);
    rate_q.delete();
    isi_q.delete();
  endtask

  // Monitor: compare each handed-out result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (isi_valid) begin
        check_eq("isi_expected", isi_q.size() != 0, 1);
        if (isi_q.size() != 0) check_eq("isi_out", isi_out, isi_q.pop_front());
      end
      if (rate_valid && rate_ready) begin
        check_eq("rate_expected", rate_q.size() != 0, 1);
        if (rate_q.size() != 0) check_eq("rate_out", rate_out, rate_q.pop_front());
      end
    end
  end

  initial begin
    logic [127:0] pat;
    rst_n      = 1'b1;
    ena        = 1'b0;
    spike_in   = 1'b0;
    rate_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rate_out", rate_out, 0);
    check_eq("rst_rate_valid", rate_valid, 0);
    check_eq("rst_isi_out", isi_out, 0);
    check_eq("rst_isi_valid", isi_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(3);

    // Steady rate: spike every 4 cycles -> 4 per window, ISI 4.
    repeat (4) rate_q.push_back(4);
    repeat (16) isi_q.push_back(4);
    run_pat(70, periodic(70, 4), 1'b1);
    check_eq("steady_overrun", overrun, 0);
    idle(4);
    check_drained("steady");

    // Long pulse counts once and yields no ISI.
    pat = '0;
    for (int i = 2; i < 12; i++) pat[i] = 1'b1;
    rate_q.push_back(1);
    run_pat(19, pat, 1'b1);
    idle(4);
    check_drained("long");

    // Count saturation: 8 spikes per window saturate a 3-bit count at 7.
    repeat (2) rate_q.push_back(7);
    repeat (16) isi_q.push_back(2);
    run_pat(36, periodic(36, 2), 1'b1);
    idle(4);
    check_drained("cnt_sat");

    // Backpressure: 2 then 3 spikes with rate_ready low.
    pat = '0;
    pat[4] = 1'b1; pat[8] = 1'b1; pat[20] = 1'b1; pat[24] = 1'b1; pat[28] = 1'b1;
    isi_q.push_back(4); isi_q.push_back(12); isi_q.push_back(4); isi_q.push_back(4);
    rate_q.push_back(3);
    run_pat(35, pat, 1'b0);
    check_eq("bp_valid", rate_valid, 1);
    check_eq("bp_rate_out", rate_out, 3);
    check_eq("bp_overrun", overrun, 1);
    rate_ready = 1'b1;
    tick();
    check_eq("bp_valid_after_xfer", rate_valid, 0);
    check_eq("bp_overrun_sticky", overrun, 1);
    ena = 1'b0;
    tick();
    check_eq("bp_overrun_cleared", overrun, 0);
    idle(4);
    check_drained("bp");

    // ISI saturation: 40 cycles apart on a 4-bit counter reads 15.
    pat = '0;
    pat[2] = 1'b1; pat[42] = 1'b1;
    rate_q.push_back(1); rate_q.push_back(0); rate_q.push_back(1);
    isi_q.push_back(15);
    run_pat(50, pat, 1'b1);
    idle(4);
    check_drained("isi_sat");

    // Asynchronous reset at window cycle 9 with 3 spikes counted.
    pat = '0;
    pat[1] = 1'b1; pat[3] = 1'b1; pat[5] = 1'b1;
    isi_q.push_back(2); isi_q.push_back(2);
    run_pat(10, pat, 1'b1);
    check_eq("pre_rst_isi_out", isi_out, 2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rate_out", rate_out, 0);
    check_eq("mid_rst_rate_valid", rate_valid, 0);
    check_eq("mid_rst_isi_out", isi_out, 0);
    check_eq("mid_rst_isi_valid", isi_valid, 0);
    check_eq("mid_rst_overrun", overrun, 0);
    ena      = 1'b0;
    spike_in = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(3);
    check_drained("rst_a");

    // After reset: 2 spikes give 2; then 3 spikes into a window cut by ena=0 for one cycle.
    pat = '0;
    pat[4] = 1'b1; pat[8] = 1'b1; pat[18] = 1'b1; pat[20] = 1'b1; pat[22] = 1'b1;
    isi_q.push_back(4); isi_q.push_back(10); isi_q.push_back(2); isi_q.push_back(2);
    rate_q.push_back(2);
    for (int c = 0; c < 27; c++) begin
      ena        = 1'b1;
      rate_ready = 1'b0;
      spike_in   = pat[c];
      tick();
      if (c == 7 + Lat) check_eq("isi_lat_before", isi_valid, 0);
      if (c == 8 + Lat) check_eq("isi_lat_pulse", isi_valid, 1);
      if (c == 9 + Lat) check_eq("isi_lat_after", isi_valid, 0);
    end
    ena = 1'b0;
    tick();
    check_eq("idle_pending_valid", rate_valid, 1);
    check_eq("idle_pending_rate", rate_out, 2);
    check_eq("idle_overrun", overrun, 0);

    // Re-enable: pending 2 drains, the interrupted partial window is discarded.
    pat = '0;
    pat[4] = 1'b1; pat[8] = 1'b1;
    rate_q.push_back(2);
    isi_q.push_back(4);
    run_pat(19, pat, 1'b1);
    idle(4);
    check_drained("ena_gap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
